// File: rtl/spi_flash_test.sv
// Key-triggered M25P16 SPI flash self-test: RDID, optional erase, page program, read-back compare.
// Define SPI_FLASH_TEST_ERASE_EN to run WREN/sector-erase/poll before programming.
module spi_flash_test #(
  parameter int CLK_DIV         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NCS_GAP         = 16,
  parameter int PP_BYTES        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key1,
  output logic ncs,
  output logic dclk,
  output logic mosi,
  input  logic miso
);

  typedef enum logic [3:0] {
    S_IDLE, S_RDID, S_WREN1, S_ERASE, S_POLL1, S_WREN2, S_PROG, S_POLL2, S_READ, S_DONE
  } state_t;

  typedef enum logic [2:0] {P_IDLE, P_START, P_SHIFT, P_HOLD, P_GAP} phase_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CMAX = (CLK_DIV > NCS_GAP) ? CLK_DIV : NCS_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(NCS_GAP - 1);

  state_t         state;
  phase_t         phase;
  logic [23:0]    id_reg;
  logic           done_flag;
  logic           err_flag;
  logic           key_meta, key_s, key_db;
  logic [DBW-1:0] deb_cnt;
  logic [CW-1:0]  div_cnt;
  logic [2:0]     bit_cnt;
  logic [8:0]     byte_cnt;
  logic [7:0]     tx_sh, rx_sh;
  logic           press, is_poll, frame_end;
  logic [7:0]     first_byte, next_byte;

  function automatic logic [7:0] tx_byte(input state_t st, input logic [8:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_RDID:           if (idx == 9'd0) b = 8'h9F;
      S_WREN1, S_WREN2: b = 8'h06;
      S_ERASE:          if (idx == 9'd0) b = 8'hD8;
      S_POLL1, S_POLL2: if (idx == 9'd0) b = 8'h05;
      S_PROG:           if (idx == 9'd0) b = 8'h02;
                        else if (idx >= 9'd4) b = idx[7:0] - 8'd4;
      S_READ:           if (idx == 9'd0) b = 8'h03;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [8:0] frame_len(input state_t st);
    case (st)
      S_RDID, S_ERASE: return 9'd4;
      S_PROG, S_READ:  return 9'(4 + PP_BYTES);
      default:         return 9'd1;
    endcase
  endfunction

  function automatic state_t next_state(input state_t st);
    case (st)
`ifdef SPI_FLASH_TEST_ERASE_EN
      S_RDID:  return S_WREN1;
`else
      S_RDID:  return S_WREN2;
`endif
      S_WREN1: return S_ERASE;
      S_ERASE: return S_POLL1;
      S_POLL1: return S_WREN2;
      S_WREN2: return S_PROG;
      S_PROG:  return S_POLL2;
      S_POLL2: return S_READ;
      S_READ:  return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

  always_comb begin
    press      = (key_s != key_db) && !key_s && (deb_cnt == DEB_LAST);
    is_poll    = (state == S_POLL1) || (state == S_POLL2);
    // Status polls end on the first byte with WIP clear rather than at a fixed length.
    frame_end  = is_poll ? ((byte_cnt != 9'd0) && !rx_sh[0])
                         : (byte_cnt == frame_len(state) - 9'd1);
    first_byte = tx_byte(state, 9'd0);
    next_byte  = tx_byte(state, byte_cnt + 9'd1);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_IDLE;
      phase     <= P_IDLE;
      ncs       <= 1'b1;
      dclk      <= 1'b0;
      mosi      <= 1'b0;
      id_reg    <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      key_db    <= 1'b1;
      deb_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
    end else begin
      key_meta <= key1;
      key_s    <= key_meta;
      if (key_s != key_db) begin
        if (deb_cnt == DEB_LAST) begin
          key_db  <= key_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end

      case (phase)
        P_IDLE: begin
          if (state == S_IDLE && press) begin
            state     <= S_RDID;
            phase     <= P_START;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
          end else if (state == S_DONE) begin
            done_flag <= 1'b1;
            state     <= S_IDLE;
          end
        end
        P_START: begin
          ncs      <= 1'b0;
          dclk     <= 1'b0;
          tx_sh    <= first_byte;
          mosi     <= first_byte[7];
          byte_cnt <= '0;
          bit_cnt  <= '0;
          div_cnt  <= '0;
          phase    <= P_SHIFT;
        end
        P_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!dclk) begin
              dclk  <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
            end else begin
              dclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (state == S_RDID) begin
                  case (byte_cnt)
                    9'd1:    id_reg[23:16] <= rx_sh;
                    9'd2:    id_reg[15:8]  <= rx_sh;
                    9'd3:    id_reg[7:0]   <= rx_sh;
                    default: ;
                  endcase
                end
                if (state == S_READ && byte_cnt >= 9'd4 && rx_sh != 8'(byte_cnt - 9'd4))
                  err_flag <= 1'b1;
                if (frame_end) begin
                  phase <= P_HOLD;
                  mosi  <= 1'b0;
                end else begin
                  byte_cnt <= is_poll ? 9'd1 : byte_cnt + 9'd1;
                  tx_sh    <= next_byte;
                  mosi     <= next_byte[7];
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                mosi    <= tx_sh[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        P_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            ncs     <= 1'b1;
            phase   <= P_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        P_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= next_state(state);
            phase   <= (next_state(state) == S_DONE) ? P_IDLE : P_START;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_test.sv
// Directed bench for spi_flash_test with a small behavioural M25P16 responder.
module tb_spi_flash_test;
  localparam int CLK_DIV = 2;
  localparam int DEB     = 20;
  localparam int GAP     = 4;
  localparam int PP      = 4;

`ifdef SPI_FLASH_TEST_ERASE_EN
  localparam int NF = 8;
  localparam int PIDX = 5;
  localparam logic [7:0] ECMD [NF] = '{8'h9F, 8'h06, 8'hD8, 8'h05, 8'h06, 8'h02, 8'h05, 8'h03};
  localparam int ELEN [NF] = '{4, 1, 4, 5, 1, 8, 4, 8};
`else
  localparam int NF = 5;
  localparam int PIDX = 2;
  localparam logic [7:0] ECMD [NF] = '{8'h9F, 8'h06, 8'h02, 8'h05, 8'h03};
  localparam int ELEN [NF] = '{4, 1, 8, 4, 8};
`endif

  logic clk = 1'b0;
  logic rst_n, key1, miso;
  logic ncs, dclk, mosi;
  int   n_assert = 0;
  int   n_fail = 0;
  int   base;
  bit   ff_mode = 1'b0;

  spi_flash_test #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .NCS_GAP(GAP), .PP_BYTES(PP)) dut (
    .clk(clk), .rst_n(rst_n), .key1(key1), .ncs(ncs), .dclk(dclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Flash responder and bus monitor, evaluated on the falling clk edge.
  int nfr = 0, bitn = 0, bytek = 0, rises = 0, busy = 0;
  int setup_cnt = 0, hold_cnt = 0, gap_cnt = 0;
  int min_setup = 1000, min_hold = 1000, min_gap = 1000, pulse_err = 0;
  bit in_frame = 0, rise_seen = 0, had_frame = 0, pd = 0;
  bit dclk_seen = 0, dclk_bad = 0, ncs_low_seen = 0;
  logic [7:0] inb = '0, cur_cmd = '0, rsp_next = '0, rsp_sh = '0;
  logic [7:0] fcmd [64];
  int         flen [64];
  logic [7:0] fb   [64][16];
  logic [7:0] mem  [256];

  always @(negedge clk) begin
    if (dclk) dclk_seen = 1'b1;
    if (dclk && ncs) dclk_bad = 1'b1;
    if (!ncs) begin
      ncs_low_seen = 1'b1;
      if (!in_frame) begin
        in_frame = 1'b1; bitn = 0; bytek = 0; rises = 0; setup_cnt = 1; rise_seen = 1'b0;
        cur_cmd = '0; rsp_sh = '0; rsp_next = '0;
        if (had_frame && gap_cnt < min_gap) min_gap = gap_cnt;
      end else if (dclk && !pd) begin
        if (!rise_seen) begin
          rise_seen = 1'b1;
          if (setup_cnt < min_setup) min_setup = setup_cnt;
        end
        rises++; hold_cnt++; bitn++;
        inb = {inb[6:0], mosi};
        if (bitn == 8) begin
          if (bytek == 0) cur_cmd = inb;
          if (nfr < 64 && bytek < 16) fb[nfr][bytek] = inb;
          if (cur_cmd == 8'h02 && bytek >= 4) mem[8'(bytek - 4)] = inb;
          bytek++; bitn = 0;
          case (cur_cmd)
            8'h9F: rsp_next = (bytek == 3) ? 8'h15 : 8'h20;
            8'h05: begin
              rsp_next = (busy > 0) ? 8'h03 : 8'h02;
              if (busy > 0) busy--;
            end
            8'h03: rsp_next = (bytek >= 4) ? (ff_mode ? 8'hFF : mem[8'(bytek - 4)]) : 8'h00;
            default: rsp_next = 8'h00;
          endcase
        end
      end else if (!dclk && pd) begin
        hold_cnt = 1;
        if (bitn == 0) rsp_sh = rsp_next;
        miso = rsp_sh[7];
        rsp_sh = {rsp_sh[6:0], 1'b0};
      end else begin
        if (!rise_seen) setup_cnt++;
        hold_cnt++;
      end
    end else begin
      miso = 1'b0;
      if (in_frame) begin
        if (nfr < 64) begin
          fcmd[nfr] = cur_cmd;
          flen[nfr] = bytek;
        end
        nfr++;
        if (rise_seen && hold_cnt < min_hold) min_hold = hold_cnt;
        if (rises != 8 * bytek) pulse_err++;
        if (cur_cmd == 8'hD8) busy = 3;
        if (cur_cmd == 8'h02) busy = 2;
        in_frame = 1'b0; had_frame = 1'b1; gap_cnt = 0;
      end
      gap_cnt++;
    end
    pd = dclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key();
    key1 = 1'b0; tick(40);
    key1 = 1'b1; tick(40);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (dut.done_flag !== 1'b1 && t < 20000) begin
      tick(1);
      t++;
    end
    check("done_timeout", 32'(t < 20000), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; key1 = 1'b1;
    tick(5);
    check("rst_ncs", 32'(ncs), 32'd1);
    check("rst_dclk", 32'(dclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_id", 32'(dut.id_reg), 32'd0);
    check("rst_done", 32'(dut.done_flag), 32'd0);
    check("rst_err", 32'(dut.err_flag), 32'd0);
    rst_n = 1'b0;

    tick(300);
    check("idle_ncs_low_seen", 32'(ncs_low_seen), 32'd0);
    check("idle_dclk_seen", 32'(dclk_seen), 32'd0);

    key1 = 1'b0; tick(DEB - 1);
    key1 = 1'b1; tick(100);
    check("glitch_no_start", 32'(ncs_low_seen), 32'd0);

    // Full sequence, with a second press while it runs.
    base = nfr;
    press_key();
    press_key();
    wait_done();
    tick(200);
    check("frame_count", 32'(nfr - base), 32'(NF));
    for (int i = 0; i < NF; i++) begin
      check($sformatf("frame%0d_cmd", i), 32'(fcmd[base + i]), 32'(ECMD[i]));
      check($sformatf("frame%0d_len", i), 32'(flen[base + i]), 32'(ELEN[i]));
    end
    for (int k = 0; k < 4 + PP; k++)
      check($sformatf("prog_byte%0d", k), 32'(fb[base + PIDX][k]),
            (k == 0) ? 32'h02 : (k < 4) ? 32'h00 : 32'(k - 4));
    for (int k = 1; k < 4; k++)
      check($sformatf("read_addr%0d", k), 32'(fb[base + NF - 1][k]), 32'h00);
    check("id_reg", 32'(dut.id_reg), 32'h202015);
    check("done_flag", 32'(dut.done_flag), 32'd1);
    check("err_flag", 32'(dut.err_flag), 32'd0);

    // Read-back returns erased data.
    ff_mode = 1'b1;
    base = nfr;
    press_key();
    wait_done();
    tick(50);
    check("ff_frame_count", 32'(nfr - base), 32'(NF));
    check("ff_err_flag", 32'(dut.err_flag), 32'd1);
    check("ff_done_flag", 32'(dut.done_flag), 32'd1);
    check("setup_min", 32'(min_setup >= CLK_DIV), 32'd1);
    check("hold_min", 32'(min_hold >= CLK_DIV), 32'd1);
    check("gap_min", 32'(min_gap >= GAP), 32'd1);
    check("pulses_per_byte", 32'(pulse_err), 32'd0);
    check("dclk_outside_ncs", 32'(dclk_bad), 32'd0);

    // Reset during page program.
    ff_mode = 1'b0;
    key1 = 1'b0; tick(40);
    key1 = 1'b1;
    begin
      int t;
      t = 0;
      while (!(in_frame && cur_cmd == 8'h02 && bytek >= 2) && t < 5000) begin
        tick(1);
        t++;
      end
      check("prog_reach_timeout", 32'(t < 5000), 32'd1);
    end
    rst_n = 1'b1;
    tick(1);
    check("abort_ncs", 32'(ncs), 32'd1);
    check("abort_dclk", 32'(dclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_id", 32'(dut.id_reg), 32'd0);
    check("abort_done", 32'(dut.done_flag), 32'd0);
    rst_n = 1'b0;
    tick(100);
    base = nfr;
    tick(100);
    check("abort_no_resume", 32'(nfr - base), 32'd0);
    press_key();
    wait_done();
    tick(50);
    check("restart_first_cmd", 32'(fcmd[base]), 32'h9F);
    check("restart_frame_count", 32'(nfr - base), 32'(NF));
    check("restart_id", 32'(dut.id_reg), 32'h202015);
    check("restart_err", 32'(dut.err_flag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_flash_test.md
SPI_FLASH_TEST -- requirements
Module: spi_flash_test

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per dclk half-period (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-low cycles required on key1 (20 ms at 50 MHz).
REQ-003 SHALL have parameter NCS_GAP, default 16, minimum clk cycles ncs stays high between commands.
REQ-004 SHALL have parameter PP_BYTES, default 16, page-program/read-back length (1..256).
REQ-005 SHALL have port clk, input, 1 bit: single system clock, 50 MHz, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port key1, input, 1 bit: push button, active-low, asynchronous (double-flop synchronised).
REQ-008 SHALL have port ncs, output, 1 bit: flash chip select, active-low.
REQ-009 SHALL have port dclk, output, 1 bit: SPI clock, mode 0.
REQ-010 SHALL have port mosi, output, 1 bit: serial data to flash, MSB first.
REQ-011 SHALL have port miso, input, 1 bit: serial data from flash.

Function
REQ-012 SHALL implement SPI mode 0: dclk idles low; mosi changes on dclk falling edge or before the first rise; miso sampled on dclk rising edge; each bit period = 2*CLK_DIV clk cycles.
REQ-013 SHALL register a press only when synchronised key1 is low for DEBOUNCE_CYCLES consecutive cycles; each press starts one sequence only if the FSM is IDLE; the next press requires release (key1 high, debounced) first.
REQ-014 SHALL run the FSM sequence IDLE -> RDID -> WREN1 -> ERASE -> POLL1 -> WREN2 -> PROG -> POLL2 -> READ -> DONE -> IDLE.
REQ-015 RDID SHALL send 0x9F, then read 3 bytes into internal id_reg[23:0] (M25P16 returns 0x202015).
REQ-016 WREN1/WREN2 SHALL send single byte 0x06.
REQ-017 ERASE SHALL send 0xD8 plus 24-bit address 0x000000.
REQ-018 POLL SHALL send 0x05 and keep ncs low, reading status bytes until bit0 (WIP) = 0; then raise ncs.
REQ-019 PROG SHALL send 0x02, address 0x000000, then PP_BYTES data bytes with value = byte index (0x00, 0x01, ...).
REQ-020 READ SHALL send 0x03, address 0x000000, then read PP_BYTES bytes, comparing each with its index; any mismatch sets internal err_flag.
REQ-021 DONE SHALL set internal done_flag; done_flag and err_flag clear at the start of the next sequence.
REQ-022 ncs SHALL fall at least CLK_DIV clk cycles before the first dclk rise and rise at least CLK_DIV cycles after the last dclk fall; each command SHALL be framed by its own ncs low period, separated by ≥NCS_GAP cycles high.
REQ-023 key1 activity during a running sequence SHALL be ignored; the sequence always completes.
REQ-024 dclk SHALL toggle only while ncs is low; exactly 8 dclk pulses per byte.

Reset
REQ-025 On rst_n high at a clk edge, the FSM SHALL go to IDLE, with ncs=1, dclk=0, mosi=0, id_reg=0, done_flag=0, err_flag=0, and debounce state cleared.
REQ-026 Reset asserted mid-command SHALL abort immediately with those values; no resume.

Configuration
REQ-027 Macro SPI_FLASH_TEST_ERASE_EN defined: WREN1, ERASE and POLL1 are executed. Undefined: the FSM goes RDID -> WREN2 directly, and PROG writes over unerased flash.

Verification
REQ-028 Reset, key1 held high 1 ms -> ncs stays 1, dclk stays 0, no activity.
REQ-029 key1 low 100 ms against the M25P16 model -> first frame 0x9F, id_reg = 0x202015.
REQ-030 Same run with SPI_FLASH_TEST_ERASE_EN -> frame order 0x9F, 0x06, 0xD8 000000, 0x05 (repeated until WIP=0), 0x06, 0x02 000000 00..0F, 0x05, 0x03 000000; done_flag=1, err_flag=0.
REQ-031 key1 low glitch of 500 cycles -> no sequence starts.
REQ-032 Model returns 0xFF data on read (erase enabled, PROG forced to skip) -> err_flag=1, done_flag=1.
REQ-033 rst_n pulsed during PROG -> ncs=1 on the next cycle, FSM in IDLE; a new press restarts from RDID.
